// File: rtl/arc4_pkg.sv
// Shared types and widths for the ARC4 sequencer and its S-memory port mux.
package arc4_pkg;

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [3:0] {
    StIdle,
    StInitGo,
    StInitAck,
    StInitRun,
    StKsaGo,
    StKsaAck,
    StKsaRun,
    StPrgaGo,
    StPrgaAck,
    StPrgaRun
  } arc4_seq_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_KSA,
    OWN_PRGA
  } arc4_owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
  } arc4_sreq_t;

  // S-port ownership depends on the state register alone, never on engine inputs.
  function automatic arc4_owner_t owner_of(arc4_seq_state_t st);
    arc4_owner_t own;
    case (st)
      StInitGo, StInitAck, StInitRun: own = OWN_INIT;
      StKsaGo, StKsaAck, StKsaRun:    own = OWN_KSA;
      StPrgaGo, StPrgaAck, StPrgaRun: own = OWN_PRGA;
      default:                        own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/arc4_seq_if.sv
// Sequencer bundle: key handshake, engine start/ready pairs, engine S-port requests and s_mem port.
interface arc4_seq_if;
  import arc4_pkg::*;

  logic              en;
  logic              rdy;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  key_out;

  logic              init_en;
  logic              ksa_en;
  logic              prga_en;
  logic              init_rdy;
  logic              ksa_rdy;
  logic              prga_rdy;

  logic [ADDR_W-1:0] init_s_addr;
  logic [DATA_W-1:0] init_s_wrdata;
  logic              init_s_wren;
  logic [ADDR_W-1:0] ksa_s_addr;
  logic [DATA_W-1:0] ksa_s_wrdata;
  logic              ksa_s_wren;
  logic [ADDR_W-1:0] prga_s_addr;
  logic [DATA_W-1:0] prga_s_wrdata;
  logic              prga_s_wren;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wrdata;
  logic              s_wren;

  // Environment side: requester, engines and s_mem.
  modport master (
    output en, key, init_rdy, ksa_rdy, prga_rdy,
    output init_s_addr, init_s_wrdata, init_s_wren,
    output ksa_s_addr, ksa_s_wrdata, ksa_s_wren,
    output prga_s_addr, prga_s_wrdata, prga_s_wren,
    input  rdy, key_out, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren
  );

  // Sequencer side.
  modport slave (
    input  en, key, init_rdy, ksa_rdy, prga_rdy,
    input  init_s_addr, init_s_wrdata, init_s_wren,
    input  ksa_s_addr, ksa_s_wrdata, ksa_s_wren,
    input  prga_s_addr, prga_s_wrdata, prga_s_wren,
    output rdy, key_out, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_smem_mux.sv
// Routes the active engine's S-port request to s_mem; OWN_NONE yields an all-zero idle port.
module arc4_smem_mux
  import arc4_pkg::*;
(
  input  arc4_owner_t owner_i,
  input  arc4_sreq_t  init_req_i,
  input  arc4_sreq_t  ksa_req_i,
  input  arc4_sreq_t  prga_req_i,
  output arc4_sreq_t  s_req_o
);

  always_comb begin
    s_req_o = '0;
    unique case (owner_i)
      OWN_INIT: s_req_o = init_req_i;
      OWN_KSA:  s_req_o = ksa_req_i;
      OWN_PRGA: s_req_o = prga_req_i;
      default:  s_req_o = '0;
    endcase
  end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 sequencer: latches a key, then runs init, ksa and prga in order over en/rdy handshakes.
// Optional ARC4_SEQ_PERF_EN adds a saturating busy-cycle counter on output 'cycles'.
module arc4_seq
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  arc4_seq_if.slave   bus
`ifdef ARC4_SEQ_PERF_EN
  ,
  output logic [31:0] cycles
`endif
);

  arc4_seq_state_t  state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             init_en, ksa_en, prga_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  // GO pulses en only once the engine is ready; ACK waits for rdy to drop, RUN for it to rise.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          key_d   = bus.key;
          state_d = StInitGo;
        end
      end
      StInitGo: begin
        if (bus.init_rdy) begin
          init_en = 1'b1;
          state_d = StInitAck;
        end
      end
      StInitAck: if (!bus.init_rdy) state_d = StInitRun;
      StInitRun: if (bus.init_rdy)  state_d = StKsaGo;
      StKsaGo: begin
        if (bus.ksa_rdy) begin
          ksa_en  = 1'b1;
          state_d = StKsaAck;
        end
      end
      StKsaAck: if (!bus.ksa_rdy) state_d = StKsaRun;
      StKsaRun: if (bus.ksa_rdy)  state_d = StPrgaGo;
      StPrgaGo: begin
        if (bus.prga_rdy) begin
          prga_en = 1'b1;
          state_d = StPrgaAck;
        end
      end
      StPrgaAck: if (!bus.prga_rdy) state_d = StPrgaRun;
      StPrgaRun: if (bus.prga_rdy)  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign bus.rdy     = (state_q == StIdle);
  assign bus.key_out = key_q;
  assign bus.init_en = init_en;
  assign bus.ksa_en  = ksa_en;
  assign bus.prga_en = prga_en;

  arc4_sreq_t init_req, ksa_req, prga_req, s_req;

  assign init_req = {bus.init_s_addr, bus.init_s_wrdata, bus.init_s_wren};
  assign ksa_req  = {bus.ksa_s_addr, bus.ksa_s_wrdata, bus.ksa_s_wren};
  assign prga_req = {bus.prga_s_addr, bus.prga_s_wrdata, bus.prga_s_wren};

  arc4_smem_mux u_smem_mux (
    .owner_i    (owner_of(state_q)),
    .init_req_i (init_req),
    .ksa_req_i  (ksa_req),
    .prga_req_i (prga_req),
    .s_req_o    (s_req)
  );

  assign bus.s_addr   = s_req.addr;
  assign bus.s_wrdata = s_req.wrdata;
  assign bus.s_wren   = s_req.wren;

`ifdef ARC4_SEQ_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == StIdle) begin
      if (bus.en) cycles_d = '0;
    end else if (cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_arc4_seq.sv
// Self-checking bench for arc4_seq with latency-programmable stub engines and an event scoreboard.
module tb_arc4_seq;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arc4_seq_if bus ();

`ifdef ARC4_SEQ_PERF_EN
  logic [31:0] cycles;
`endif

  arc4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARC4_SEQ_PERF_EN
    ,
    .cycles(cycles)
`endif
  );

  // Stub engines: rdy drops on accepted en and rises again lat[i] edges later.
  int unsigned lat [3];
  int unsigned cnt [3];
  logic [2:0]  stub_rdy;
  logic [2:0]  stub_en;
  logic [7:0]  own_a [3];
  logic [7:0]  own_d [3];

  assign stub_en = {bus.prga_en, bus.ksa_en, bus.init_en};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_rdy <= 3'b111;
      for (int i = 0; i < 3; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stub_rdy[i] && stub_en[i]) begin
          stub_rdy[i] <= 1'b0;
          cnt[i]      <= lat[i] - 1;
        end else if (!stub_rdy[i]) begin
          if (cnt[i] == 0) stub_rdy[i] <= 1'b1;
          else             cnt[i]      <= cnt[i] - 1;
        end
      end
    end
  end

  assign bus.init_rdy      = stub_rdy[0];
  assign bus.ksa_rdy       = stub_rdy[1];
  assign bus.prga_rdy      = stub_rdy[2];
  assign bus.init_s_addr   = 8'h11;
  assign bus.init_s_wrdata = 8'hA1;
  assign bus.init_s_wren   = 1'b1;
  assign bus.ksa_s_addr    = 8'h22;
  assign bus.ksa_s_wrdata  = 8'hA2;
  assign bus.ksa_s_wren    = 1'b1;
  assign bus.prga_s_addr   = 8'h33;
  assign bus.prga_s_wrdata = 8'hA3;
  assign bus.prga_s_wren   = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, act, exp);
    end
  endtask

  // Event codes: 1 init_en, 2 ksa_en, 3 prga_en, 4 rdy returned.
  task automatic sb_pop(input string tag, input int ev);
    if (exp_q.size() == 0) check_eq(tag, ev, 0);
    else                   check_eq(tag, ev, exp_q.pop_front());
  endtask

  initial begin
    int  cyc = 0;
    int  prga_rise = 0;
    logic prev_rdy = 1'b1;
    logic prev_prga = 1'b1;
    own_a = '{8'h11, 8'h22, 8'h33};
    own_d = '{8'hA1, 8'hA2, 8'hA3};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy  = 1'b1;
        prev_prga = 1'b1;
      end else begin
        cyc++;
        if (bus.init_en) sb_pop("ev_init", 1);
        if (bus.ksa_en)  sb_pop("ev_ksa", 2);
        if (bus.prga_en) sb_pop("ev_prga", 3);
        if (stub_rdy[2] && !prev_prga) prga_rise = cyc;
        if (bus.rdy && !prev_rdy) begin
          sb_pop("ev_done", 4);
          check_eq("done_lat", cyc - prga_rise, 1);
        end
        for (int i = 0; i < 3; i++) begin
          if (!stub_rdy[i])
            check_eq("own_sport", {bus.s_wren, bus.s_addr, bus.s_wrdata},
                     {1'b1, own_a[i], own_d[i]});
        end
        prev_rdy  = bus.rdy;
        prev_prga = stub_rdy[2];
      end
    end
  end

  task automatic start_op(input logic [KEY_W-1:0] k);
    @(negedge clk);
    bus.key = k;
    bus.en  = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(4);
    @(posedge clk);
    #1;
    bus.en  = 1'b0;
    bus.key = 24'h5A5A5A;
    check_eq("acc_rdy", bus.rdy, 0);
    check_eq("acc_init_en", bus.init_en, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (bus.rdy) break;
      k++;
    end
    check_eq("done_timeout", k < budget, 1);
  endtask

  task automatic wait_busy(input int idx, input int budget);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (!stub_rdy[idx]) break;
      k++;
    end
    check_eq("busy_timeout", k < budget, 1);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("idle_rdy", bus.rdy, 1);
      check_eq("idle_sport", {bus.s_wren, bus.s_addr, bus.s_wrdata}, 0);
    end
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.key = '0;
    lat     = '{4, 4, 4};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdy", bus.rdy, 1);
    check_eq("rst_key_out", bus.key_out, 0);
    check_eq("rst_en", {bus.init_en, bus.ksa_en, bus.prga_en}, 0);
    check_eq("rst_sport", {bus.s_wren, bus.s_addr, bus.s_wrdata}, 0);
`ifdef ARC4_SEQ_PERF_EN
    check_eq("rst_cycles", cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal run, with a busy-time en carrying a different key during ksa.
    lat = '{256, 768, 40};
    start_op(24'h000018);
    check_eq("nom_key_out", bus.key_out, 24'h000018);
    wait_busy(1, 2000);
    repeat (5) @(negedge clk);
    bus.key = 24'hABCDEF;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en  = 1'b0;
    check_eq("busy_key_out", bus.key_out, 24'h000018);
    wait_done(3000);
    check_eq("nom_key_hold", bus.key_out, 24'h000018);
    idle_check(3);
    check_eq("nom_sb_empty", exp_q.size(), 0);

    // Short run for the busy-cycle count: each phase costs its latency plus two cycles.
    lat = '{10, 20, 30};
    start_op(24'h123456);
    wait_done(500);
    check_eq("short_key_out", bus.key_out, 24'h123456);
`ifdef ARC4_SEQ_PERF_EN
    check_eq("perf_total", cycles, (10 + 2) + (20 + 2) + (30 + 2));
`endif
    idle_check(5);
`ifdef ARC4_SEQ_PERF_EN
    check_eq("perf_hold", cycles, (10 + 2) + (20 + 2) + (30 + 2));
`endif

    // Mid-run reset during prga, then a clean restart.
    start_op(24'h000042);
`ifdef ARC4_SEQ_PERF_EN
    check_eq("perf_clr", cycles, 0);
`endif
    wait_busy(2, 500);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_rdy", bus.rdy, 1);
    check_eq("mrst_prga_en", bus.prga_en, 0);
    check_eq("mrst_sport", {bus.s_wren, bus.s_addr, bus.s_wrdata}, 0);
    check_eq("mrst_key_out", bus.key_out, 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    start_op(24'h000077);
    wait_done(500);
    check_eq("restart_key_out", bus.key_out, 24'h000077);
    idle_check(2);
    check_eq("end_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
